// File: rtl/ddr2_port_arbiter_pkg.sv
// ddr2_port_arbiter_pkg: shared command codes, FSM states and grant directions
package ddr2_port_arbiter_pkg;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    ARB      = 2'd1,
    ISSUE    = 2'd2,
    GAP      = 2'd3
  } state_t;
  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;
endpackage

// File: rtl/ddr2_rd_credit.sv
// ddr2_rd_credit: outstanding read-word counter, read headroom check, underflow flag
//   issue_i/issue_bl_i : read command issued this cycle with burst length minus 1
//   req_bl_i           : pending read request burst length minus 1 (headroom check)
//   pop_i/empty_i      : read FIFO pop strobe and empty flag
//   count_o            : words committed but not yet popped
//   room_o             : pending read fits in the read FIFO
//   underflow_o        : sticky, a pop happened with nothing outstanding
module ddr2_rd_credit #(
  parameter int RD_FIFO_DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_i,
  input  logic [5:0] issue_bl_i,
  input  logic [5:0] req_bl_i,
  input  logic       pop_i,
  input  logic       empty_i,
  output logic [6:0] count_o,
  output logic       room_o,
  output logic       underflow_o
);
  localparam logic [7:0] DEPTH8 = 8'(RD_FIFO_DEPTH);
  logic [6:0] count_q, count_d;
  logic       uf_q, uf_d, pop_ok, pop_zero;
  logic [7:0] sum;
  always_comb begin
    pop_zero = pop_i & ~empty_i & (count_q == 7'd0);
    pop_ok   = pop_i & ~empty_i & (count_q != 7'd0);
    sum      = {1'b0, count_q} + (issue_i ? {2'b0, issue_bl_i} + 8'd1 : 8'd0) - {7'd0, pop_ok};
    count_d  = (sum > DEPTH8) ? DEPTH8[6:0] : sum[6:0];
    uf_d     = uf_q | pop_zero;
    room_o   = ({1'b0, count_q} + {2'b0, req_bl_i} + 8'd1) <= DEPTH8;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      uf_q    <= uf_d;
    end
  end
  assign count_o     = count_q;
  assign underflow_o = uf_q;
endmodule

// File: rtl/ddr2_port_arbiter.sv
// ddr2_port_arbiter: round-robin write/read arbiter for the MIG port-0 command interface
//   wr_req/wr_addr/wr_bl/wr_ack : write requester handshake
//   rd_req/rd_addr/rd_bl/rd_ack : read requester handshake
//   p0_cmd_*                    : registered MIG command strobe, instr, bl, address
//   p0_cmd_full/p0_wr_count     : MIG command FIFO full and write FIFO occupancy
//   p0_rd_en/p0_rd_empty        : monitored read FIFO pop
//   rd_outstanding/busy/rd_underflow : status
module ddr2_port_arbiter
  import ddr2_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 30,
  parameter int RD_FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  calib_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [5:0]            wr_bl,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [5:0]            rd_bl,
  output logic                  rd_ack,
  output logic                  p0_cmd_en,
  output logic [2:0]            p0_cmd_instr,
  output logic [5:0]            p0_cmd_bl,
  output logic [ADDR_WIDTH-1:0] p0_cmd_byte_addr,
  input  logic                  p0_cmd_full,
  input  logic [6:0]            p0_wr_count,
  input  logic                  p0_rd_en,
  input  logic                  p0_rd_empty,
  output logic [6:0]            rd_outstanding,
  output logic                  busy,
  output logic                  rd_underflow
);
  state_t                state_q, state_d;
  grant_t                last_q, last_d, grant;
  logic                  wr_ok, rd_ok, rd_room, go;
  logic                  cmd_en_q, wr_ack_q, rd_ack_q;
  logic [2:0]            instr_q;
  logic [5:0]            bl_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  ddr2_rd_credit #(.RD_FIFO_DEPTH(RD_FIFO_DEPTH)) u_credit (
    .clk         (clk),
    .reset       (reset),
    .issue_i     (state_q == ISSUE && instr_q == CMD_RD),
    .issue_bl_i  (bl_q),
    .req_bl_i    (rd_bl),
    .pop_i       (p0_rd_en),
    .empty_i     (p0_rd_empty),
    .count_o     (rd_outstanding),
    .room_o      (rd_room),
    .underflow_o (rd_underflow)
  );
  always_comb begin
    wr_ok   = calib_done & ~p0_cmd_full & wr_req & (({1'b0, wr_bl} + 7'd1) <= p0_wr_count);
    rd_ok   = calib_done & ~p0_cmd_full & rd_req & rd_room;
    // on a tie the direction not served last time wins
    grant   = (wr_ok & rd_ok) ? ((last_q == GRANT_RD) ? GRANT_WR : GRANT_RD) : (rd_ok ? GRANT_RD : GRANT_WR);
    go      = (state_q == ARB) & (wr_ok | rd_ok);
    last_d  = (state_q == ISSUE) ? ((instr_q == CMD_RD) ? GRANT_RD : GRANT_WR) : last_q;
    state_d = state_q;
    unique case (state_q)
      WAIT_CAL: state_d = calib_done ? ARB : WAIT_CAL;
      ARB:      state_d = !calib_done ? WAIT_CAL : (go ? ISSUE : ARB);
      ISSUE:    state_d = GAP;
      default:  state_d = ARB;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_CAL;
      last_q   <= GRANT_RD;
      cmd_en_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      instr_q  <= '0;
      bl_q     <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cmd_en_q <= go;
      wr_ack_q <= go & (grant == GRANT_WR);
      rd_ack_q <= go & (grant == GRANT_RD);
      if (go) begin
        instr_q <= (grant == GRANT_RD) ? CMD_RD : CMD_WR;
        bl_q    <= (grant == GRANT_RD) ? rd_bl : wr_bl;
        addr_q  <= (grant == GRANT_RD) ? rd_addr : wr_addr;
      end
    end
  end
  assign p0_cmd_en        = cmd_en_q;
  assign wr_ack           = wr_ack_q;
  assign rd_ack           = rd_ack_q;
  assign p0_cmd_instr     = instr_q;
  assign p0_cmd_bl        = bl_q;
  assign p0_cmd_byte_addr = addr_q;
  assign busy             = (state_q == ISSUE) | (state_q == GAP) | (rd_outstanding != 7'd0);
endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// tb_ddr2_port_arbiter: scoreboard bench with a cycle-level reference model of the arbiter
`timescale 1ns/1ps
module tb_ddr2_port_arbiter;
  localparam int AW = 30;
  logic          clk = 1'b0, reset = 1'b1, calib_done = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0, p0_cmd_full = 1'b0, p0_rd_en = 1'b0, p0_rd_empty = 1'b1;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [5:0]    wr_bl = '0, rd_bl = '0;
  logic [6:0]    p0_wr_count = '0;
  logic          wr_ack, rd_ack, p0_cmd_en, busy, rd_underflow;
  logic [2:0]    p0_cmd_instr;
  logic [5:0]    p0_cmd_bl;
  logic [AW-1:0] p0_cmd_byte_addr;
  logic [6:0]    rd_outstanding;

  ddr2_port_arbiter #(.ADDR_WIDTH(AW), .RD_FIFO_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_bl(wr_bl), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_bl(rd_bl), .rd_ack(rd_ack),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full), .p0_wr_count(p0_wr_count),
    .p0_rd_en(p0_rd_en), .p0_rd_empty(p0_rd_empty), .rd_outstanding(rd_outstanding),
    .busy(busy), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]    instr;
    logic [5:0]    bl;
    logic [AW-1:0] addr;
  } cmd_t;
  cmd_t exp_q[$];

  // reference model: one decision every third edge while calibrated, read credit lands an edge later
  bit m_arb, m_last_rd, m_uf;
  int m_cool, m_out, m_pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_arb = 0; m_cool = 0; m_last_rd = 1; m_out = 0; m_pend = 0; m_uf = 0;
      exp_q.delete();
    end else begin
      bit pop, we, re, g;
      int nxt;
      cmd_t c;
      pop = p0_rd_en && !p0_rd_empty;
      if (pop && m_out == 0) m_uf = 1;
      nxt = m_out + m_pend - ((pop && m_out > 0) ? 1 : 0);
      if (nxt > 64) nxt = 64;
      m_pend = 0;
      if (m_cool > 0) m_cool--;
      else if (!m_arb) m_arb = calib_done;
      else if (!calib_done) m_arb = 0;
      else if (!p0_cmd_full) begin
        we = wr_req && (int'(p0_wr_count) >= int'(wr_bl) + 1);
        re = rd_req && (m_out + int'(rd_bl) + 1 <= 64);
        if (we || re) begin
          g = (we && re) ? !m_last_rd : re;
          c.instr = g ? 3'b001 : 3'b000;
          c.bl    = g ? rd_bl : wr_bl;
          c.addr  = g ? rd_addr : wr_addr;
          exp_q.push_back(c);
          m_last_rd = g;
          m_cool = 2;
          if (g) m_pend = int'(rd_bl) + 1;
        end
      end
      m_out = nxt;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("outstanding", 64'(rd_outstanding), 64'(m_out));
      chk("underflow", 64'(rd_underflow), 64'(m_uf));
      chk("busy", 64'(busy), 64'(m_cool != 0 || m_out != 0));
      if (p0_cmd_en) begin
        if (exp_q.size() == 0) chk("unexpected_cmd", 64'(p0_cmd_en), 64'd0);
        else begin
          cmd_t e;
          e = exp_q.pop_front();
          chk("cmd_instr", 64'(p0_cmd_instr), 64'(e.instr));
          chk("cmd_bl", 64'(p0_cmd_bl), 64'(e.bl));
          chk("cmd_addr", 64'(p0_cmd_byte_addr), 64'(e.addr));
          chk("cmd_acks", 64'({wr_ack, rd_ack}), (e.instr == 3'b001) ? 64'd1 : 64'd2);
        end
      end else begin
        if (exp_q.size() != 0) begin
          chk("missing_cmd", 64'(p0_cmd_en), 64'd1);
          exp_q.delete();
        end
        chk("ack_idle", 64'({wr_ack, rd_ack}), 64'd0);
      end
    end
  end

  bit hold = 0;
  int n_cmd = 0, t_cyc = 0;
  int ev_cyc[$];
  logic [2:0] ev_ins[$];
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      t_cyc++;
      if (p0_cmd_en) begin
        n_cmd++;
        ev_cyc.push_back(t_cyc);
        ev_ins.push_back(p0_cmd_instr);
      end
      if (wr_ack && !hold) wr_req = 0;
      if (rd_ack && !hold) rd_req = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; calib_done = 0; wr_req = 0; rd_req = 0; p0_cmd_full = 0;
    p0_rd_en = 0; p0_rd_empty = 1; p0_wr_count = 0; hold = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_en"}, 64'(p0_cmd_en), 64'd0);
    chk({tag, "_acks"}, 64'({wr_ack, rd_ack}), 64'd0);
    chk({tag, "_instr_bl"}, 64'({p0_cmd_instr, p0_cmd_bl}), 64'd0);
    chk({tag, "_addr"}, 64'(p0_cmd_byte_addr), 64'd0);
    chk({tag, "_status"}, 64'({rd_outstanding, busy, rd_underflow}), 64'd0);
  endtask

  task automatic rnd_step();
    @(negedge clk);
    if (!wr_req || wr_ack) begin
      wr_req  = $urandom_range(0, 2) != 0;
      wr_addr = AW'($urandom);
      wr_bl   = 6'($urandom_range(0, 63));
    end
    if (!rd_req || rd_ack) begin
      rd_req  = $urandom_range(0, 2) != 0;
      rd_addr = AW'($urandom);
      rd_bl   = 6'($urandom_range(0, 31));
    end
    calib_done  = $urandom_range(0, 49) != 0;
    p0_cmd_full = $urandom_range(0, 9) == 0;
    p0_wr_count = 7'($urandom_range(0, 64));
    p0_rd_en    = $urandom_range(0, 1) == 1;
    p0_rd_empty = $urandom_range(0, 3) == 0;
  endtask

  initial begin
    bit found;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 0;
    // single write after calibration at 1 us
    wr_req = 1; wr_bl = 15; p0_wr_count = 16; wr_addr = 30'h100;
    while ($time < 1000) @(negedge clk);
    calib_done = 1;
    cyc(1);
    chk("t1_lat_early", 64'(p0_cmd_en), 64'd0);
    @(negedge clk);
    chk("t1_cmd", 64'({p0_cmd_en, wr_ack, rd_ack, p0_cmd_instr, p0_cmd_bl}), 64'({3'b110, 3'b000, 6'd15}));
    chk("t1_addr", 64'(p0_cmd_byte_addr), 64'h100);
    wr_req = 0;
    cyc(3);
    // write data not yet loaded, then loaded
    wr_req = 1; wr_bl = 15; p0_wr_count = 15; n_cmd = 0;
    cyc(8);
    chk("t2_blocked", 64'(n_cmd), 64'd0);
    p0_wr_count = 16;
    cyc(4);
    chk("t2_issue", 64'(n_cmd), 64'd1);
    // both requests held: alternating grants, first to write
    do_reset();
    wr_req = 1; wr_bl = 3; p0_wr_count = 64; wr_addr = 30'h2000;
    rd_req = 1; rd_bl = 0; rd_addr = 30'h3000; hold = 1; calib_done = 1;
    ev_cyc.delete(); ev_ins.delete(); n_cmd = 0;
    cyc(14);
    chk("t3_count", 64'(n_cmd >= 4), 64'd1);
    if (ev_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", 64'(ev_ins[i]), (i % 2 == 0) ? 64'd0 : 64'd1);
      for (int i = 0; i < 3; i++) chk("t3_spacing", 64'(ev_cyc[i+1] - ev_cyc[i]), 64'd3);
    end
    // read FIFO headroom
    do_reset();
    rd_req = 1; rd_bl = 31; rd_addr = 30'h40; hold = 1; calib_done = 1; n_cmd = 0;
    cyc(15);
    chk("t4_two_issued", 64'(n_cmd), 64'd2);
    chk("t4_full_credit", 64'(rd_outstanding), 64'd64);
    hold = 0; p0_rd_en = 1; p0_rd_empty = 0;
    cyc(32);
    p0_rd_en = 0; p0_rd_empty = 1;
    chk("t4_after_pops", 64'(rd_outstanding), 64'd32);
    chk("t4_still_two", 64'(n_cmd), 64'd2);
    cyc(5);
    chk("t4_third", 64'(n_cmd), 64'd3);
    chk("t4_refill", 64'(rd_outstanding), 64'd64);
    // issue and pop in the same cycle
    do_reset();
    calib_done = 1; rd_req = 1; rd_bl = 9;
    cyc(6);
    chk("t5_ten", 64'(rd_outstanding), 64'd10);
    rd_req = 1; rd_bl = 7; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = rd_ack;
    end
    chk("t5_ack_seen", 64'(found), 64'd1);
    rd_req = 0; p0_rd_en = 1; p0_rd_empty = 0;
    @(negedge clk);
    p0_rd_en = 0; p0_rd_empty = 1;
    chk("t5_seventeen", 64'(rd_outstanding), 64'd17);
    // pop with nothing outstanding
    do_reset();
    p0_rd_en = 1; p0_rd_empty = 0;
    cyc(1);
    p0_rd_en = 0; p0_rd_empty = 1;
    chk("t5_uf_set", 64'({rd_underflow, rd_outstanding}), 64'({1'b1, 7'd0}));
    cyc(5);
    chk("t5_uf_sticky", 64'(rd_underflow), 64'd1);
    // asynchronous reset in the middle of an issue
    do_reset();
    wr_req = 1; wr_bl = 0; p0_wr_count = 1; wr_addr = 30'h55; calib_done = 1; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = p0_cmd_en;
    end
    chk("t6_in_issue", 64'(found), 64'd1);
    #2 reset = 1;
    #1 chk_reset_outputs("t6_async");
    @(negedge clk);
    reset = 0;
    cyc(1);
    chk("t6_wait_cal", 64'(p0_cmd_en), 64'd0);
    cyc(1);
    chk("t6_reissue", 64'(p0_cmd_en), 64'd1);
    // command FIFO full blocks everything
    do_reset();
    wr_req = 1; wr_bl = 0; p0_wr_count = 8; rd_req = 1; rd_bl = 0; hold = 1;
    p0_cmd_full = 1; calib_done = 1; n_cmd = 0;
    cyc(12);
    chk("t6_full_blocks", 64'(n_cmd), 64'd0);
    p0_cmd_full = 0;
    cyc(4);
    chk("t6_full_release", 64'(n_cmd > 0), 64'd1);
    // randomized traffic against the model
    do_reset();
    repeat (3000) rnd_step();
    do_reset();
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
